// File: rtl/dsa_control_fsm_simd.sv
// Control FSM for the bilinear-interpolation DSA: walks the output image
// row-major, LANES pixels per group, sequencing fetch -> datapath -> write.
// Ports: clk, rst (async, active-high), enable, abort, img_width_out,
//   img_height_out; fetch_req/fetch_done, dp_start/dp_done handshakes;
//   write_enable, lane_mask, current_x, current_y, pixels_processed,
//   busy, ready.
// Optional macro DSA_STEP_MODE_EN adds step_mode, step_pulse, step_wait
// and a STEP_WAIT state between groups.
module dsa_control_fsm_simd #(
    parameter int LANES          = 4,
    parameter int COORD_W        = 16,
    parameter int IMG_WIDTH_MAX  = 512,
    parameter int IMG_HEIGHT_MAX = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               abort,
    input  logic [COORD_W-1:0] img_width_out,
    input  logic [COORD_W-1:0] img_height_out,
    output logic               fetch_req,
    input  logic               fetch_done,
    output logic               dp_start,
    input  logic               dp_done,
    output logic               write_enable,
    output logic [LANES-1:0]   lane_mask,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic [31:0]        pixels_processed,
    output logic               busy,
    output logic               ready
`ifdef DSA_STEP_MODE_EN
    ,
    input  logic               step_mode,
    input  logic               step_pulse,
    output logic               step_wait
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_REQ,
        S_WAIT_FETCH,
        S_INTERP,
        S_WRITE,
        S_NEXT,
        S_DONE
`ifdef DSA_STEP_MODE_EN
        ,
        S_STEP_WAIT
`endif
    } state_t;

    localparam logic [COORD_W:0] LANES_W = (COORD_W+1)'(LANES);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [31:0]        pp_q, pp_d;

    logic               in_grp;
    logic [COORD_W:0]   x_adv;
    logic               row_more;
    logic               last_row;
    logic [31:0]        popcnt;

    // Compares are done one bit wider so x+i never wraps past w.
    assign x_adv    = {1'b0, x_q} + LANES_W;
    assign row_more = x_adv < {1'b0, w_q};
    assign last_row = ({1'b0, y_q} + (COORD_W+1)'(1)) == {1'b0, h_q};

    assign in_grp = (state_q == S_REQ) || (state_q == S_WAIT_FETCH) ||
                    (state_q == S_INTERP) || (state_q == S_WRITE) ||
                    (state_q == S_NEXT);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = in_grp &&
                (({1'b0, x_q} + (COORD_W+1)'(i)) < {1'b0, w_q});
        end
    end

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < LANES; i++) begin
            popcnt = popcnt + 32'(lane_mask[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        pp_d    = pp_q;
        // Abort wins over everything and freezes the counters.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_INIT;
                        x_d     = '0;
                        y_d     = '0;
                        pp_d    = '0;
                    end
                end
                S_INIT: begin
                    w_d = img_width_out;
                    h_d = img_height_out;
                    if ((img_width_out == '0) || (img_height_out == '0))
                        state_d = S_DONE;
                    else
                        state_d = S_REQ;
                end
                S_REQ: state_d = S_WAIT_FETCH;
                S_WAIT_FETCH: begin
                    if (fetch_done) state_d = S_INTERP;
                end
                S_INTERP: begin
                    if (dp_done) state_d = S_WRITE;
                end
                S_WRITE: state_d = S_NEXT;
                S_NEXT: begin
                    pp_d = pp_q + popcnt;
                    if (row_more) begin
                        x_d = x_adv[COORD_W-1:0];
                    end else begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                    end
                    if (!row_more && last_row)
                        state_d = S_DONE;
`ifdef DSA_STEP_MODE_EN
                    else if (step_mode)
                        state_d = S_STEP_WAIT;
`endif
                    else
                        state_d = S_REQ;
                end
                S_DONE: begin
                    if (!enable) state_d = S_IDLE;
                end
`ifdef DSA_STEP_MODE_EN
                S_STEP_WAIT: begin
                    if (step_pulse) state_d = S_REQ;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            pp_q    <= pp_d;
        end
    end

    assign fetch_req        = (state_q == S_REQ);
    assign dp_start         = (state_q == S_INTERP);
    assign write_enable     = (state_q == S_WRITE);
    assign current_x        = x_q;
    assign current_y        = y_q;
    assign pixels_processed = pp_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ready            = (state_q == S_DONE);
`ifdef DSA_STEP_MODE_EN
    assign step_wait        = (state_q == S_STEP_WAIT);
`endif

    a_dim_bound: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_INIT) |->
        ((img_width_out <= COORD_W'(IMG_WIDTH_MAX)) &&
         (img_height_out <= COORD_W'(IMG_HEIGHT_MAX))));

endmodule

// File: tb/tb_dsa_control_fsm_simd.sv
// Randomized scoreboard bench for dsa_control_fsm_simd.
// Reference groups are generated from width/height with plain loops.
module tb_dsa_control_fsm_simd;

    localparam int LANES = 4;
    localparam int CW    = 16;

    typedef struct packed {
        logic [CW-1:0]    x;
        logic [CW-1:0]    y;
        logic [LANES-1:0] m;
    } grp_t;

    logic             clk = 0;
    logic             rst = 1;
    logic             enable = 0;
    logic             abort = 0;
    logic [CW-1:0]    img_w = 0;
    logic [CW-1:0]    img_h = 0;
    logic             fetch_req, dp_start, write_enable;
    logic             fd_r = 0, dd_r = 0;
    logic             stray_fd = 0, stray_dd = 0;
    logic             stray_en = 0;
    logic [LANES-1:0] lane_mask;
    logic [CW-1:0]    current_x, current_y;
    logic [31:0]      pixels_processed;
    logic             busy, ready;
`ifdef DSA_STEP_MODE_EN
    logic             step_mode = 0;
    logic             step_pulse = 0;
    logic             step_wait;
`endif

    int checks = 0;
    int failures = 0;
    int fd_lo = 0, fd_hi = 0, dd_lo = 0, dd_hi = 0;
    int extra_cyc = 0;
    int fetch_cnt = 0, we_cnt = 0;
    int dp_len = 0;
    grp_t exp_q[$];
    int   exp_dp[$];

    dsa_control_fsm_simd #(.LANES(LANES), .COORD_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .abort            (abort),
        .img_width_out    (img_w),
        .img_height_out   (img_h),
        .fetch_req        (fetch_req),
        .fetch_done       (fd_r | stray_fd),
        .dp_start         (dp_start),
        .dp_done          (dd_r | stray_dd),
        .write_enable     (write_enable),
        .lane_mask        (lane_mask),
        .current_x        (current_x),
        .current_y        (current_y),
        .pixels_processed (pixels_processed),
        .busy             (busy),
        .ready            (ready)
`ifdef DSA_STEP_MODE_EN
        ,
        .step_mode        (step_mode),
        .step_pulse       (step_pulse),
        .step_wait        (step_wait)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Fetch responder: fetch_done after a chosen number of wait cycles.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (fetch_req) begin
                d = $urandom_range(fd_hi, fd_lo);
                extra_cyc += d;
                @(negedge clk);
                repeat (d) @(negedge clk);
                fd_r = 1;
                @(negedge clk);
                fd_r = 0;
            end
        end
    end

    // Datapath responder; dp_start must stay high d+1 cycles.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (dp_start) begin
                d = $urandom_range(dd_hi, dd_lo);
                extra_cyc += d;
                exp_dp.push_back(d + 1);
                repeat (d) @(negedge clk);
                dd_r = 1;
                @(negedge clk);
                dd_r = 0;
            end
        end
    end

    // Out-of-state dones that must be ignored.
    always @(negedge clk) begin
        stray_fd = stray_en && dp_start;
        stray_dd = stray_en && fetch_req;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        grp_t g;
        if (!rst) begin
            if (fetch_req) fetch_cnt++;
            if (write_enable) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    g = exp_q.pop_front();
                    chk("wr_x", current_x, g.x);
                    chk("wr_y", current_y, g.y);
                    chk("wr_mask", lane_mask, g.m);
                    chk("wr_busy", busy, 1);
                end
            end
            if (dp_start) begin
                dp_len++;
            end else if (dp_len > 0) begin
                if (exp_dp.size() == 0)
                    chk("unexpected_dp", dp_len, 0);
                else
                    chk("dp_start_len", dp_len, exp_dp.pop_front());
                dp_len = 0;
            end
        end
    end

    task automatic push_groups(int w, int h, int max_groups, output int ng);
        grp_t g;
        ng = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx += LANES) begin
                g.x = CW'(xx);
                g.y = CW'(yy);
                for (int i = 0; i < LANES; i++) g.m[i] = (xx + i < w);
                if (ng < max_groups) exp_q.push_back(g);
                ng++;
            end
        end
    endtask

    task automatic run_image(int w, int h);
        int ng, cyc, f0, w0, e0;
        push_groups(w, h, 1 << 30, ng);
        img_w = CW'(w);
        img_h = CW'(h);
        f0 = fetch_cnt;
        w0 = we_cnt;
        e0 = extra_cyc;
        enable = 1;
        cyc = 0;
        while (!ready && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                img_w = CW'($urandom_range(20, 0));
                img_h = CW'($urandom_range(6, 0));
            end
        end
        chk("ready_seen", ready, 1);
        chk("latency", cyc, 2 + 5 * ng + (extra_cyc - e0));
        chk("pixels", pixels_processed, w * h);
        chk("fetch_reqs", fetch_cnt - f0, ng);
        chk("writes", we_cnt - w0, ng);
        chk("busy_in_done", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        enable = 0;
        @(negedge clk);
        chk("ready_drop", ready, 0);
    endtask

    task automatic abort_run();
        int ng, n, cyc;
        fd_lo = 0; fd_hi = 0; dd_lo = 0; dd_hi = 0;
        push_groups(8, 1, 1, ng);
        img_w = 8;
        img_h = 1;
        enable = 1;
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (fetch_req) n++;
            if (n == 1) begin
                fd_lo = 20;
                fd_hi = 20;
            end
        end
        chk("abort_reach_g2", n, 2);
        @(negedge clk);
        abort = 1;
        enable = 0;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_pixels", pixels_processed, 4);
        chk("abort_hold_x", current_x, 4);
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_sb_empty", exp_q.size(), 0);
        fd_lo = 0;
        fd_hi = 0;
    endtask

`ifdef DSA_STEP_MODE_EN
    task automatic step_run();
        int ng, nf, cyc;
        fd_lo = 0; fd_hi = 0; dd_lo = 0; dd_hi = 0;
        push_groups(8, 1, 1 << 30, ng);
        img_w = 8;
        img_h = 1;
        step_mode = 1;
        enable = 1;
        nf = 0;
        cyc = 0;
        while (!step_wait && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (fetch_req) nf++;
        end
        chk("step_wait_seen", step_wait, 1);
        chk("step_fetch1", nf, 1);
        nf = 0;
        repeat (6) begin
            @(negedge clk);
            if (fetch_req) nf++;
        end
        chk("step_hold_nofetch", nf, 0);
        chk("step_wait_hold", step_wait, 1);
        step_pulse = 1;
        @(negedge clk);
        step_pulse = 0;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("step_ready", ready, 1);
        chk("step_pixels", pixels_processed, 8);
        step_mode = 0;
        enable = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        int w, h;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_mask", lane_mask, 0);
        chk("rst_x", current_x, 0);
        chk("rst_pp", pixels_processed, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_fetch", fetch_req, 0);
        chk("idle_we", write_enable, 0);

        run_image(4, 2);
        run_image(5, 1);
        run_image(0, 7);
        run_image(3, 0);

        dd_lo = 3; dd_hi = 3;
        stray_en = 1;
        run_image(3, 1);
        stray_en = 0;
        dd_lo = 0; dd_hi = 0;

        abort_run();
        run_image(4, 2);

        for (int k = 0; k < 25; k++) begin
            w = $urandom_range(13, 0);
            h = $urandom_range(4, 0);
            fd_lo = 0; fd_hi = $urandom_range(3, 0);
            dd_lo = 0; dd_hi = $urandom_range(3, 0);
            stray_en = $urandom_range(1, 0) == 1;
            run_image(w, h);
        end
        stray_en = 0;
        fd_lo = 0; fd_hi = 0; dd_lo = 0; dd_hi = 0;

`ifdef DSA_STEP_MODE_EN
        step_run();
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
